// File: rtl/uart_alu_interface.sv
// UART-to-ALU sequencer: collects operand A, operand B and an opcode from
// the UART receiver, then sends the ALU result back through the transmitter.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   rx_data, rx_done    - received byte and its one-cycle strobe
//   tx_done             - transmitter finished the current byte
//   alu_result          - combinational ALU result for alu_a/alu_b/alu_op
//   alu_a, alu_b        - registered operands
//   alu_op              - registered opcode (low OP_W bits of the op byte)
//   tx_data, tx_start   - byte to transmit and its one-cycle start pulse
//   busy                - a result is being sent
//   overrun             - sticky: a byte arrived while busy and was dropped
module uart_alu_interface #(
    parameter int N    = 8,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    rx_data,
    input  logic            rx_done,
    input  logic            tx_done,
    input  logic [N-1:0]    alu_result,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    output logic [N-1:0]    tx_data,
    output logic            tx_start,
    output logic            busy,
    output logic            overrun
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        SEND,
        WAIT_TX
    } state_t;

    state_t state;
    state_t state_next;

    // Opcode uses only the low OP_W bits; the rest of the byte is ignored.
    generate
        if (OP_W < N) begin : g_unused_hi
            logic unused_rx_hi;
            assign unused_rx_hi = ^rx_data[N-1:OP_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        unique case (state)
            WAIT_A:  if (rx_done) state_next = WAIT_B;
            WAIT_B:  if (rx_done) state_next = WAIT_OP;
            WAIT_OP: if (rx_done) state_next = SEND;
            SEND: begin
                busy       = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                busy = 1'b1;
                if (tx_done) state_next = WAIT_A;
            end
            default: state_next = WAIT_A;
        endcase
    end

    // Datapath: operands only change in the collection states, so they stay
    // stable for the ALU while the result is being sent.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                WAIT_A: begin
                    if (rx_done) begin
                        alu_a   <= rx_data;
                        overrun <= 1'b0;
                    end
                end
                WAIT_B: begin
                    if (rx_done) alu_b <= rx_data;
                end
                WAIT_OP: begin
                    if (rx_done) alu_op <= rx_data[OP_W-1:0];
                end
                SEND: begin
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                    if (rx_done) overrun <= 1'b1;
                end
                WAIT_TX: begin
                    if (rx_done) overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
